// File: rtl/ram_arbiter_if.sv
// Request/grant bundle between the two requesters, the arbiter and the data RAM.
// The master side drives requests and RAM read data; the slave side is the arbiter.
interface ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [1:0]            req;
  logic [1:0]            lock;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output req, lock, we, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt, rvalid, rdata, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req, lock, we, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt, rvalid, rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a single-port data RAM with burst lock, hold limit
// and a read-return pipeline that tags read data with the issuing port.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  ram_arbiter_if.slave bus
);

  localparam int unsigned HoldW     = $clog2(MAX_HOLD + 1);
  localparam int unsigned LastStage = RD_LATENCY - 1;
  localparam logic [HoldW-1:0] MaxHold = HoldW'(MAX_HOLD);

  logic             ptr_q, ptr_d;
  logic             owner_valid_q, owner_valid_d;
  logic             owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RD_LATENCY-1:0] rv_valid_q;
  logic [RD_LATENCY-1:0] rv_port_q;

  logic gnt_any;
  logic gsel;
  logic rd_issue;

  // Arbitration; gated by reset so nothing is issued while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gsel    = 1'b0;
    if (i_rst_n) begin
      unique case (bus.req)
        2'b01: begin
          gnt_any = 1'b1;
          gsel    = 1'b0;
        end
        2'b10: begin
          gnt_any = 1'b1;
          gsel    = 1'b1;
        end
        2'b11: begin
          gnt_any = 1'b1;
          if (owner_valid_q && (hold_q < MaxHold)) begin
            gsel = owner_q;
          end else begin
            gsel = ~ptr_q;
          end
        end
        default: begin
          gnt_any = 1'b0;
          gsel    = 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt = gnt_any ? (gsel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (gnt_any) begin
      bus.ram_we    = bus.we[gsel];
      bus.ram_addr  = gsel ? bus.addr1 : bus.addr0;
      bus.ram_wdata = gsel ? bus.wdata1 : bus.wdata0;
    end
  end

  assign rd_issue = gnt_any & ~bus.we[gsel];

  // An owner that withdraws its request loses the lock immediately.
  always_comb begin
    ptr_d         = ptr_q;
    owner_valid_d = owner_valid_q & bus.req[owner_q];
    owner_d       = owner_q;
    hold_d        = '0;
    if (gnt_any) begin
      ptr_d         = gsel;
      owner_valid_d = bus.lock[gsel];
      owner_d       = gsel;
      if (owner_valid_q && (owner_q == gsel) && bus.req[~gsel]) begin
        hold_d = (hold_q == MaxHold) ? MaxHold : hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q         <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      hold_q        <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      hold_q        <= hold_d;
    end
  end

  // Read-return pipeline: one {valid, port} stage per cycle of RAM latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rv_valid_q <= '0;
      rv_port_q  <= '0;
    end else begin
      rv_valid_q[0] <= rd_issue;
      rv_port_q[0]  <= gsel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rv_valid_q[i] <= rv_valid_q[i-1];
        rv_port_q[i]  <= rv_port_q[i-1];
      end
    end
  end

  assign bus.rvalid = {rv_valid_q[LastStage] &  rv_port_q[LastStage],
                       rv_valid_q[LastStage] & ~rv_port_q[LastStage]};
  assign bus.rdata  = bus.ram_rdata;

  gnt_onehot_a : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(bus.gnt));
  rvalid_onehot_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                     $onehot0(bus.rvalid));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (read latency 1 and 3) share the same
// stimulus, each with its own behavioural RAM.
module tb_ram_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam logic [15:0] A0 = 16'h00A0;
  localparam logic [15:0] B0 = 16'h00B0;
  localparam logic [15:0] D0 = 16'h00D0;
  localparam logic [15:0] D1 = 16'h00D1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .MAX_HOLD(8)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1.slave)
  );

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .MAX_HOLD(8)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus3.slave)
  );

  function automatic logic [15:0] init_word(input int i);
    return (i == 16) ? 16'hBEEF : 16'h1000 + 16'(i);
  endfunction

  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] rd1;
  logic [15:0] rd3 [3];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
    end else if (bus1.ram_we) begin
      mem1[bus1.ram_addr[7:0]] <= bus1.ram_wdata;
    end
    rd1 <= mem1[bus1.ram_addr[7:0]];
  end
  assign bus1.ram_rdata = rd1;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
    end else if (bus3.ram_we) begin
      mem3[bus3.ram_addr[7:0]] <= bus3.ram_wdata;
    end
    rd3[0] <= mem3[bus3.ram_addr[7:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign bus3.ram_rdata = rd3[2];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] d0;
    logic [1:0]  egnt;
    logic        ewe;
    logic [15:0] eaddr;
    logic [15:0] ewdata;
    logic [1:0]  erv;
    logic        chkrd;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl [14];

  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d0);
    bus1.req = req;  bus1.lock = lock;  bus1.we = we;
    bus1.addr0 = a0; bus1.addr1 = a1;   bus1.wdata0 = d0; bus1.wdata1 = D1;
    bus3.req = req;  bus3.lock = lock;  bus3.we = we;
    bus3.addr0 = a0; bus3.addr1 = a1;   bus3.wdata0 = d0; bus3.wdata1 = D1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(2'b00, 2'b00, 2'b00, A0, B0, D0);
    repeat (n) next_cycle();
  endtask

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b01, 1'b0, A0, D0, 2'b00, 1'b0, 16'h0};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b10, 1'b0, B0, D1, 2'b01, 1'b1, 16'h10A0};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b01, 1'b0, A0, D0, 2'b10, 1'b1, 16'h10B0};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b10, 1'b0, B0, D1, 2'b01, 1'b0, 16'h0};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b01, 1'b0, A0, D0, 2'b10, 1'b0, 16'h0};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b10, 1'b0, B0, D1, 2'b01, 1'b0, 16'h0};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, A0, B0, D0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b10, 1'b0, 16'h0};
    tbl[7]  = '{2'b01, 2'b00, 2'b00, A0, B0, D0, 2'b01, 1'b0, A0, D0, 2'b00, 1'b0, 16'h0};
    tbl[8]  = '{2'b10, 2'b00, 2'b00, A0, B0, D0, 2'b10, 1'b0, B0, D1, 2'b01, 1'b0, 16'h0};
    tbl[9]  = '{2'b11, 2'b00, 2'b00, A0, B0, D0, 2'b01, 1'b0, A0, D0, 2'b10, 1'b0, 16'h0};
    tbl[10] = '{2'b01, 2'b00, 2'b01, 16'h0004, B0, 16'h1234, 2'b01, 1'b1, 16'h0004, 16'h1234,
                2'b01, 1'b0, 16'h0};
    tbl[11] = '{2'b00, 2'b00, 2'b00, A0, B0, D0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0};
    tbl[12] = '{2'b10, 2'b00, 2'b00, A0, 16'h0004, D0, 2'b10, 1'b0, 16'h0004, D1, 2'b00, 1'b0,
                16'h0};
    tbl[13] = '{2'b00, 2'b00, 2'b00, A0, B0, D0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b10, 1'b1,
                16'h1234};

    // Reset held with both ports requesting.
    drive(2'b11, 2'b00, 2'b00, A0, B0, D0);
    rst_n = 1'b0;
    load  = 1'b1;
    next_cycle();
    load = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset_gnt", 32'(bus1.gnt), 32'h0);
    chk("reset_ram_we", 32'(bus1.ram_we), 32'h0);
    chk("reset_rvalid", 32'(bus1.rvalid), 32'h0);
    chk("reset_ram_addr", 32'(bus1.ram_addr), 32'h0);
    chk("reset_ram_wdata", 32'(bus1.ram_wdata), 32'h0);
    chk("reset_gnt_lat3", 32'(bus3.gnt), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Round-robin, single requests, write then read-back.
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].req, tbl[k].lock, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].d0);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", k), 32'(bus1.gnt), 32'(tbl[k].egnt));
      chk($sformatf("vec%0d_ram_we", k), 32'(bus1.ram_we), 32'(tbl[k].ewe));
      chk($sformatf("vec%0d_ram_addr", k), 32'(bus1.ram_addr), 32'(tbl[k].eaddr));
      chk($sformatf("vec%0d_ram_wdata", k), 32'(bus1.ram_wdata), 32'(tbl[k].ewdata));
      chk($sformatf("vec%0d_rvalid", k), 32'(bus1.rvalid), 32'(tbl[k].erv));
      if (tbl[k].chkrd) chk($sformatf("vec%0d_rdata", k), 32'(bus1.rdata), 32'(tbl[k].erd));
      next_cycle();
    end

    // Read latency 1 versus 3 on port 1.
    idle(4);
    drive(2'b10, 2'b00, 2'b00, A0, 16'h0010, D0);
    @(negedge clk);
    chk("lat_gnt", 32'(bus1.gnt), 32'h2);
    chk("lat_ram_addr", 32'(bus1.ram_addr), 32'h0010);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, A0, B0, D0);
    @(negedge clk);
    chk("lat1_rvalid", 32'(bus1.rvalid), 32'h2);
    chk("lat1_rdata", 32'(bus1.rdata), 32'hBEEF);
    chk("lat3_rvalid_t1", 32'(bus3.rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("lat3_rvalid_t2", 32'(bus3.rvalid), 32'h0);
    chk("lat1_rvalid_t2", 32'(bus1.rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("lat3_rvalid_t3", 32'(bus3.rvalid), 32'h2);
    chk("lat3_rdata", 32'(bus3.rdata), 32'hBEEF);
    next_cycle();
    @(negedge clk);
    chk("lat3_rvalid_t4", 32'(bus3.rvalid), 32'h0);
    next_cycle();

    // Lock with hold limit from a fresh reset.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(2'b11, 2'b01, 2'b00, A0, B0, D0);
      @(negedge clk);
      chk($sformatf("hold%0d_gnt", k), 32'(bus1.gnt), (k == 9) ? 32'h2 : 32'h1);
      next_cycle();
    end

    // Uncontested lock never counts toward the hold limit.
    for (int k = 0; k < 12; k++) begin
      drive(2'b01, 2'b01, 2'b00, A0, B0, D0);
      @(negedge clk);
      chk($sformatf("solo%0d_gnt", k), 32'(bus1.gnt), 32'h1);
      next_cycle();
    end
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, 2'b01, 2'b00, A0, B0, D0);
      @(negedge clk);
      chk($sformatf("contend%0d_gnt", k), 32'(bus1.gnt), (k == 8) ? 32'h2 : 32'h1);
      next_cycle();
    end

    // Owner withdrawing its request releases the lock.
    drive(2'b01, 2'b01, 2'b00, A0, B0, D0);
    @(negedge clk);
    chk("drop_lockgrant", 32'(bus1.gnt), 32'h1);
    next_cycle();
    drive(2'b00, 2'b01, 2'b00, A0, B0, D0);
    @(negedge clk);
    chk("drop_idle", 32'(bus1.gnt), 32'h0);
    next_cycle();
    drive(2'b11, 2'b00, 2'b00, A0, B0, D0);
    @(negedge clk);
    chk("drop_rr_gnt", 32'(bus1.gnt), 32'h2);
    next_cycle();

    // Reset while a read is in flight.
    idle(4);
    drive(2'b01, 2'b00, 2'b00, A0, B0, D0);
    @(negedge clk);
    chk("midrst_gnt", 32'(bus3.gnt), 32'h1);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, A0, B0, D0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_in%0d_rv3", k), 32'(bus3.rvalid), 32'h0);
      chk($sformatf("midrst_in%0d_rv1", k), 32'(bus1.rvalid), 32'h0);
      next_cycle();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_out%0d_rv3", k), 32'(bus3.rvalid), 32'h0);
      chk($sformatf("midrst_out%0d_rv1", k), 32'(bus1.rvalid), 32'h0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
